// File: rtl/axi4_lite_pkg.sv
// ----------------------------------------------------------------------------
// axi4_lite_pkg
// Shared types for the AXI4-Lite register file slice.
//   resp_t     : AXI response codes returned on B and R.
//   wr_state_t : write-side FSM states.
//   rd_state_t : read-side FSM states.
//   idxWidth() : register index width for a given register count (min 1 bit).
// ----------------------------------------------------------------------------
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

  // A single register still needs a one-bit index so that vectors never
  // collapse to zero width.
  function automatic int idxWidth(input int numRegs);
    return (numRegs > 1) ? $clog2(numRegs) : 1;
  endfunction

endpackage

// File: rtl/axi4_lite_regfile_if.sv
// ----------------------------------------------------------------------------
// axi4_lite_regfile_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   slave  modport : used by the register file.
//   master modport : used by whatever drives the bus (e.g. a testbench).
// ----------------------------------------------------------------------------
interface axi4_lite_regfile_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   s_awaddr;
  logic                    s_awvalid;
  logic                    s_awready;
  logic [DATA_WIDTH-1:0]   s_wdata;
  logic [DATA_WIDTH/8-1:0] s_wstrb;
  logic                    s_wvalid;
  logic                    s_wready;
  logic [1:0]              s_bresp;
  logic                    s_bvalid;
  logic                    s_bready;
  logic [ADDR_WIDTH-1:0]   s_araddr;
  logic                    s_arvalid;
  logic                    s_arready;
  logic [DATA_WIDTH-1:0]   s_rdata;
  logic [1:0]              s_rresp;
  logic                    s_rvalid;
  logic                    s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, output s_awready,
    input  s_wdata, s_wstrb, s_wvalid, output s_wready,
    output s_bresp, s_bvalid, input  s_bready,
    input  s_araddr, s_arvalid, output s_arready,
    output s_rdata, s_rresp, s_rvalid, input  s_rready
  );

  modport master (
    output s_awaddr, s_awvalid, input  s_awready,
    output s_wdata, s_wstrb, s_wvalid, input  s_wready,
    input  s_bresp, s_bvalid, output s_bready,
    output s_araddr, s_arvalid, input  s_arready,
    input  s_rdata, s_rresp, s_rvalid, output s_rready
  );

endinterface

// File: rtl/axi4_lite_wr_ctrl.sv
// ----------------------------------------------------------------------------
// axi4_lite_wr_ctrl
// Write side of the register file: captures AW and W independently, decodes
// the target register, produces the B response and a commit strobe for the
// storage array.
//   clk, rst              : clock, async active-high reset
//   i_aw*/o_awready       : write address channel
//   i_w*/o_wready         : write data channel
//   o_bresp/o_bvalid/i_bready : write response channel
//   o_commit              : one-cycle strobe, an OKAY write lands this edge
//   o_idx/o_wdata/o_wstrb : target register, data and byte enables
// ----------------------------------------------------------------------------
module axi4_lite_wr_ctrl
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  localparam int STRB_W    = DATA_WIDTH / 8,
  localparam int IDX_W     = idxWidth(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [STRB_W-1:0]     i_wstrb,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  output logic                  o_commit,
  output logic [IDX_W-1:0]      o_idx,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [STRB_W-1:0]     o_wstrb
);

  localparam int ADDR_LSB = $clog2(STRB_W);

  wr_state_t             r_state;
  wr_state_t             w_nextState;
  logic                  r_awHeld;
  logic                  r_wHeld;
  logic [ADDR_WIDTH-1:0] r_awAddr;
  logic [DATA_WIDTH-1:0] r_wData;
  logic [STRB_W-1:0]     r_wStrb;
  logic                  r_bvalid;
  resp_t                 r_bresp;

  logic                  w_awHs;
  logic                  w_wHs;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_idxFull;
  logic                  w_inRange;
  resp_t                 w_resp;

  // Readiness depends only on registered state, so no valid input can
  // ripple combinationally into a ready output.
  assign o_awready = (r_state == WR_IDLE) && !r_awHeld;
  assign o_wready  = (r_state == WR_IDLE) && !r_wHeld;
  assign w_awHs    = i_awvalid && o_awready;
  assign w_wHs     = i_wvalid && o_wready;

  // A beat captured in an earlier cycle wins; otherwise use the live bus so a
  // beat arriving at the commit edge needs no extra cycle.
  assign w_addr    = r_awHeld ? r_awAddr : i_awaddr;
  assign o_wdata   = r_wHeld  ? r_wData  : i_wdata;
  assign o_wstrb   = r_wHeld  ? r_wStrb  : i_wstrb;
  assign w_commit  = (r_state == WR_IDLE) && (r_awHeld || w_awHs) && (r_wHeld || w_wHs);

  // Decode: whole shifted address is range-checked so aliases above the
  // register count never wrap onto a real register.
  assign w_idxFull = w_addr >> ADDR_LSB;
  assign w_inRange = w_idxFull < ADDR_WIDTH'(NUM_REGS);
  assign o_idx     = w_idxFull[IDX_W-1:0];

  always_comb begin
    w_resp = OKAY;
    if (!w_inRange)
      w_resp = DECERR;
    else if (RO_MASK[o_idx])
      w_resp = SLVERR;
  end

  assign o_commit = w_commit && (w_resp == OKAY);
  assign o_bvalid = r_bvalid;
  assign o_bresp  = r_bresp;

  // Write FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= WR_IDLE;
    else
      r_state <= w_nextState;
  end

  // Write FSM next state: leave idle at the commit edge, return once the
  // response has been accepted.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      WR_IDLE: if (w_commit) w_nextState = WR_RESP;
      WR_RESP: if (i_bready) w_nextState = WR_IDLE;
      default: w_nextState = WR_IDLE;
    endcase
  end

  // Holding registers and the B response. Both holding registers stay
  // marked full through the response phase and are released together on
  // the bready edge, which keeps both readys low while B is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_awHeld <= 1'b0;
      r_wHeld  <= 1'b0;
      r_awAddr <= '0;
      r_wData  <= '0;
      r_wStrb  <= '0;
      r_bvalid <= 1'b0;
      r_bresp  <= OKAY;
    end else begin
      case (r_state)
        WR_IDLE: begin
          if (w_awHs) begin
            r_awHeld <= 1'b1;
            r_awAddr <= i_awaddr;
          end
          if (w_wHs) begin
            r_wHeld <= 1'b1;
            r_wData <= i_wdata;
            r_wStrb <= i_wstrb;
          end
          if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_resp;
          end
        end
        WR_RESP: begin
          if (i_bready) begin
            r_bvalid <= 1'b0;
            r_awHeld <= 1'b0;
            r_wHeld  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axi4_lite_regfile.sv
// ----------------------------------------------------------------------------
// axi4_lite_regfile
// Parametrised AXI4-Lite slave register file with per-register read-only
// control, parallel register export and per-register write pulses.
//   clk, rst      : clock, async active-high reset
//   bus           : AXI4-Lite slave port (AW, W, B, AR, R)
//   reg_q         : all registers, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr_pulse  : bit i high for one cycle after a successful write to i
// ----------------------------------------------------------------------------
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  axi4_lite_regfile_if.slave             bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int IDX_W    = idxWidth(NUM_REGS);
  localparam int ADDR_LSB = $clog2(STRB_W);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_wrPulse;
  rd_state_t             r_rdState;
  rd_state_t             w_rdNext;
  logic [DATA_WIDTH-1:0] r_rdata;
  resp_t                 r_rresp;
  logic                  r_rvalid;

  logic                  w_commit;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_W-1:0]     w_wstrb;
  logic                  w_arHs;
  logic [ADDR_WIDTH-1:0] w_arIdxFull;
  logic [IDX_W-1:0]      w_arIdx;
  logic                  w_arInRange;

  axi4_lite_wr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_wrCtrl (
    .clk       (clk),
    .rst       (rst),
    .i_awaddr  (bus.s_awaddr),
    .i_awvalid (bus.s_awvalid),
    .o_awready (bus.s_awready),
    .i_wdata   (bus.s_wdata),
    .i_wstrb   (bus.s_wstrb),
    .i_wvalid  (bus.s_wvalid),
    .o_wready  (bus.s_wready),
    .o_bresp   (bus.s_bresp),
    .o_bvalid  (bus.s_bvalid),
    .i_bready  (bus.s_bready),
    .o_commit  (w_commit),
    .o_idx     (w_idx),
    .o_wdata   (w_wdata),
    .o_wstrb   (w_wstrb)
  );

  // Storage array: byte-lane merge on commit, one-hot write pulse that is
  // cleared every cycle it is not re-armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
      r_wrPulse <= '0;
    end else begin
      r_wrPulse <= '0;
      if (w_commit) begin
        for (int b = 0; b < STRB_W; b++)
          if (w_wstrb[b])
            r_regs[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
        r_wrPulse[w_idx] <= 1'b1;
      end
    end
  end

  // Flatten the array onto the export bus.
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++)
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
  end

  assign reg_wr_pulse = r_wrPulse;

  // Read decode mirrors the write side; out-of-range reads return zero.
  assign bus.s_arready = (r_rdState == RD_IDLE);
  assign w_arHs        = bus.s_arvalid && bus.s_arready;
  assign w_arIdxFull   = bus.s_araddr >> ADDR_LSB;
  assign w_arInRange   = w_arIdxFull < ADDR_WIDTH'(NUM_REGS);
  assign w_arIdx       = w_arIdxFull[IDX_W-1:0];

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rdState <= RD_IDLE;
    else
      r_rdState <= w_rdNext;
  end

  // Read FSM next state.
  always_comb begin
    w_rdNext = r_rdState;
    case (r_rdState)
      RD_IDLE: if (w_arHs) w_rdNext = RD_RESP;
      RD_RESP: if (bus.s_rready) w_rdNext = RD_IDLE;
      default: w_rdNext = RD_IDLE;
    endcase
  end

  // Read data capture. Sampling r_regs at the handshake edge naturally
  // returns the pre-write value when a write commits on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rresp  <= OKAY;
      r_rvalid <= 1'b0;
    end else if (r_rdState == RD_IDLE) begin
      if (w_arHs) begin
        r_rdata  <= w_arInRange ? r_regs[w_arIdx] : '0;
        r_rresp  <= w_arInRange ? OKAY : DECERR;
        r_rvalid <= 1'b1;
      end
    end else if (bus.s_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign bus.s_rdata  = r_rdata;
  assign bus.s_rresp  = r_rresp;
  assign bus.s_rvalid = r_rvalid;

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// ----------------------------------------------------------------------------
// tb_axi4_lite_regfile
// Self-checking bench for axi4_lite_regfile (32-bit data, 16 registers,
// register 0 read-only). Expected values come from an array model of the
// register file and the address/response rules.
// ----------------------------------------------------------------------------
module tb_axi4_lite_regfile;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam logic [NR-1:0] RO = 16'h0001;

  logic clk;
  logic rst;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0]    reg_wr_pulse;

  int checkCount;
  int errorCount;
  logic [DW-1:0] model [NR];

  axi4_lite_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .RO_MASK    (RO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .reg_q        (reg_q),
    .reg_wr_pulse (reg_wr_pulse)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference response rule for an address.
  function automatic logic [1:0] expResp(input logic [31:0] addr, input bit isWrite);
    int idx;
    idx = int'(addr >> 2);
    if (idx >= NR) return 2'b11;
    if (isWrite && RO[idx]) return 2'b10;
    return 2'b00;
  endfunction

  // Drives AW and W with independent start delays, then checks the B
  // response, write pulse and register export in the cycle after the later
  // handshake. Returns positioned #1 after that edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int awDly, input int wDly);
    int c;
    bit awDone, wDone, awHs, wHs;
    int idx;
    logic [1:0] resp;
    logic [NR-1:0] expPulse;
    c = 0; awDone = 0; wDone = 0;
    idx  = int'(addr >> 2);
    resp = expResp(addr, 1'b1);
    bus.s_awaddr = addr;
    bus.s_wdata  = data;
    bus.s_wstrb  = strb;
    while (!(awDone && wDone)) begin
      if (c > 50) begin
        checkOutput("wr_timeout", 64'd0, 64'd1);
        bus.s_awvalid = 1'b0;
        bus.s_wvalid  = 1'b0;
        return;
      end
      bus.s_awvalid = !awDone && (c >= awDly);
      bus.s_wvalid  = !wDone && (c >= wDly);
      awHs = bus.s_awvalid && bus.s_awready;
      wHs  = bus.s_wvalid && bus.s_wready;
      @(posedge clk); #1;
      c++;
      if (awHs) awDone = 1;
      if (wHs)  wDone  = 1;
      if (!(awDone && wDone)) checkOutput("bvalid_early", 64'(bus.s_bvalid), 64'd0);
    end
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    expPulse = '0;
    if (resp == 2'b00) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      expPulse[idx] = 1'b1;
    end
    checkOutput("bvalid", 64'(bus.s_bvalid), 64'd1);
    checkOutput("bresp", 64'(bus.s_bresp), 64'(resp));
    checkOutput("wr_pulse", 64'(reg_wr_pulse), 64'(expPulse));
    if (idx < NR) checkOutput("reg_q_wr", 64'(reg_q[idx*DW +: DW]), 64'(model[idx]));
  endtask

  // With bready high, the cycle after a commit must show B gone and the
  // pulse cleared.
  task automatic finishWrite();
    @(posedge clk); #1;
    checkOutput("bvalid_clear", 64'(bus.s_bvalid), 64'd0);
    checkOutput("pulse_clear", 64'(reg_wr_pulse), 64'd0);
  endtask

  // Issues a read once arready allows, checks R in the following cycle.
  task automatic applyRead(input logic [31:0] addr);
    int c;
    bit hs;
    int idx;
    logic [31:0] expData;
    c = 0; hs = 0;
    idx = int'(addr >> 2);
    expData = (idx < NR) ? model[idx] : 32'd0;
    bus.s_araddr  = addr;
    bus.s_arvalid = 1'b1;
    while (!hs) begin
      if (c > 50) begin
        checkOutput("rd_timeout", 64'd0, 64'd1);
        bus.s_arvalid = 1'b0;
        return;
      end
      hs = bus.s_arready;
      @(posedge clk); #1;
      c++;
    end
    bus.s_arvalid = 1'b0;
    checkOutput("rvalid", 64'(bus.s_rvalid), 64'd1);
    checkOutput("rdata", 64'(bus.s_rdata), 64'(expData));
    checkOutput("rresp", 64'(bus.s_rresp), 64'(expResp(addr, 1'b0)));
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    checkCount = 0;
    errorCount = 0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    rst = 1'b1;
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0;
    bus.s_wdata = '0;  bus.s_wstrb = '0; bus.s_wvalid = 1'b0;
    bus.s_bready = 1'b1;
    bus.s_araddr = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_bvalid", 64'(bus.s_bvalid), 64'd0);
    checkOutput("rst_rvalid", 64'(bus.s_rvalid), 64'd0);
    checkOutput("rst_bresp", 64'(bus.s_bresp), 64'd0);
    checkOutput("rst_rresp", 64'(bus.s_rresp), 64'd0);
    checkOutput("rst_rdata", 64'(bus.s_rdata), 64'd0);
    checkOutput("rst_pulse", 64'(reg_wr_pulse), 64'd0);
    checkOutput("rst_regq", 64'(|reg_q), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("awready", 64'(bus.s_awready), 64'd1);
    checkOutput("wready", 64'(bus.s_wready), 64'd1);
    checkOutput("arready", 64'(bus.s_arready), 64'd1);

    // Simultaneous AW/W write, then read back.
    applyStimulus(32'h04, 32'hDEADBEEF, 4'hF, 0, 0);
    finishWrite();
    applyRead(32'h04);

    // W three cycles ahead of AW with partial strobes over an all-ones reg.
    applyStimulus(32'h08, 32'hFFFFFFFF, 4'hF, 0, 0);
    finishWrite();
    applyStimulus(32'h08, 32'h11223344, 4'b0101, 3, 0);
    checkOutput("merge_reg2", 64'(reg_q[2*DW +: DW]), 64'hFF22FF44);
    finishWrite();

    // Read-only, out-of-range and all-zero-strobe writes.
    applyStimulus(32'h00, 32'h12345678, 4'hF, 0, 1);
    finishWrite();
    applyStimulus(32'h40, 32'h55AA55AA, 4'hF, 1, 0);
    finishWrite();
    applyRead(32'h40);
    applyStimulus(32'h04, 32'h00000000, 4'h0, 0, 0);
    finishWrite();

    // Back-pressure on B while a read proceeds.
    bus.s_bready = 1'b0;
    applyStimulus(32'h14, 32'hCAFEF00D, 4'hF, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) applyRead(32'h04);
      else begin
        @(posedge clk); #1;
      end
      checkOutput("bp_bvalid", 64'(bus.s_bvalid), 64'd1);
      checkOutput("bp_bresp", 64'(bus.s_bresp), 64'd0);
      checkOutput("bp_awready", 64'(bus.s_awready), 64'd0);
      checkOutput("bp_wready", 64'(bus.s_wready), 64'd0);
    end
    bus.s_bready = 1'b1;
    finishWrite();
    checkOutput("bp_awready_back", 64'(bus.s_awready), 64'd1);

    // Same-edge read and write of register 3.
    applyStimulus(32'h0C, 32'h0000000A, 4'hF, 0, 0);
    finishWrite();
    bus.s_awaddr = 32'h0C; bus.s_wdata = 32'h0000000B; bus.s_wstrb = 4'hF;
    bus.s_araddr = 32'h0C;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
    checkOutput("coll_rdata", 64'(bus.s_rdata), 64'h0A);
    checkOutput("coll_bvalid", 64'(bus.s_bvalid), 64'd1);
    model[3] = 32'h0000000B;
    finishWrite();
    applyRead(32'h0C);

    // Randomised mix of writes and reads, including out-of-range and RO.
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 19) << 2) | $urandom_range(0, 3);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        applyStimulus(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        finishWrite();
      end else begin
        applyRead(a);
      end
    end
    for (int i = 0; i < NR; i++)
      checkOutput("final_regq", 64'(reg_q[i*DW +: DW]), 64'(model[i]));

    // Reset while a B response is pending.
    bus.s_bready = 1'b0;
    applyStimulus(32'h08, 32'h87654321, 4'hF, 0, 0);
    rst = 1'b1;
    #2;
    checkOutput("midrst_bvalid", 64'(bus.s_bvalid), 64'd0);
    checkOutput("midrst_regq", 64'(|reg_q), 64'd0);
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.s_bready = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_awready", 64'(bus.s_awready), 64'd1);
    applyStimulus(32'h04, 32'h12345678, 4'hF, 0, 0);
    finishWrite();
    applyRead(32'h04);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/axi4_lite_regfile.md
# axi4_lite_regfile

Parametrised AXI4-Lite slave register file: the next-generation slave for the AXI4-Lite subsystem, generalised in data width, register count and per-register access mode. It accepts AW and W independently and in any order, merges write strobes per byte lane, returns DECERR/SLVERR on illegal accesses, and honours back-pressure on B and R. All register contents are exported in parallel, with per-register write pulses for downstream logic.

## Interface
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width; 32 or 64 only.
- NUM_REGS, 16, number of registers; 1..256.
- RO_MASK, '0, NUM_REGS bits; bit i=1 makes register i read-only.
- clk  in  1  single clock; everything is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_awaddr in ADDR_WIDTH / s_awvalid in 1 / s_awready out 1: write address channel.
- s_wdata in DATA_WIDTH / s_wstrb in DATA_WIDTH/8 / s_wvalid in 1 / s_wready out 1: write data channel.
- s_bresp out 2 / s_bvalid out 1 / s_bready in 1: write response channel.
- s_araddr in ADDR_WIDTH / s_arvalid in 1 / s_arready out 1: read address channel.
- s_rdata out DATA_WIDTH / s_rresp out 2 / s_rvalid out 1 / s_rready in 1: read data channel.
- reg_q  out  NUM_REGS*DATA_WIDTH  all registers; register i is at [i*DATA_WIDTH +: DATA_WIDTH].
- reg_wr_pulse  out  NUM_REGS  bit i is high for one cycle after a successful write to register i.

## Operation
- Address decode: ADDR_LSB = log2(DATA_WIDTH/8). idx = addr >> ADDR_LSB; address bits below ADDR_LSB are ignored.
- Response priority: idx >= NUM_REGS gives DECERR (2'b11). Otherwise, a write to an RO_MASK register gives SLVERR (2'b10). Otherwise OKAY (2'b00).
- Write FSM states: WR_IDLE and WR_RESP.
  - In WR_IDLE, AW and W are each captured into a holding register. Each handshake happens only while its holding register is empty.
  - When both holding registers are full, or are being filled at this edge, the write commits at that same edge.
  - Commit for OKAY: update the byte lanes selected by s_wstrb only. Pulse reg_wr_pulse[idx]. Set bvalid with bresp. Go to WR_RESP.
  - Commit for DECERR or SLVERR: no register change and no pulse. The error response is still issued.
  - WR_RESP: hold bvalid and bresp stable until s_bready. On the bready edge, clear both holding registers and go to WR_IDLE.
  - s_awready = (WR_IDLE && !aw_held). s_wready = (WR_IDLE && !w_held).
- Read FSM states: RD_IDLE and RD_RESP.
  - s_arready = RD_IDLE.
  - On the AR handshake, register rdata and rresp, raise rvalid, and go to RD_RESP.
  - In-range reads return OKAY. RO registers are readable.
  - Out-of-range reads return rdata = 0 with DECERR.
  - RD_RESP holds rdata, rresp and rvalid stable until s_rready, then returns to RD_IDLE.
- Read and write channels are fully independent and may be active in the same cycle.
- Same-edge collision: an AR handshake and a write commit to the same register on the same edge return the pre-write value. The next read returns the new value.
- Strobe of all zeros: the write is accepted with OKAY, no bytes change, and reg_wr_pulse still fires.

## Timing
- Reset values:
  - All registers, s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata and reg_wr_pulse are 0. The holding registers are empty.
  - s_awready, s_wready and s_arready are 1 from the first cycle after rst deasserts.
- Write latency: s_bvalid rises the cycle after the later of the AW and W handshakes.
  - reg_q shows the new value from that same cycle.
  - reg_wr_pulse is high in that cycle only.
- Read latency: s_rvalid rises the cycle after the AR handshake.
- Throughput: with bready and rready held high, one write every 2 cycles and one read every 2 cycles.
- Reset mid-operation: held AW/W beats and any pending B or R response are discarded. rst clears registers regardless of channel state.
- No combinational path from any *valid/*ready input to any *ready output.

## Structure
- Shared package axi4_lite_pkg holds:
  - resp_t enum: OKAY, EXOKAY, SLVERR, DECERR.
  - wr_state_t enum: WR_IDLE, WR_RESP.
  - rd_state_t enum: RD_IDLE, RD_RESP.
- One sub-module, axi4_lite_wr_ctrl, covers AW/W capture, the write FSM, decode and response generation. It outputs a commit strobe, idx and wstrb to the storage array in the top.
- The read FSM and the storage array stay in axi4_lite_regfile.

## Test plan
All scenarios use DATA_WIDTH=32, NUM_REGS=16, RO_MASK=16'h0001.
- Write 0xDEADBEEF to 0x04, AW and W in the same cycle, bready high:
  - bvalid rises the next cycle with OKAY.
  - reg_q[63:32] = 0xDEADBEEF and reg_wr_pulse = 16'h0002 for one cycle.
  - A read of 0x04 returns 0xDEADBEEF with OKAY.
- W (0x11223344, strb 4'b0101) arrives 3 cycles before AW (0x08), with register 2 previously 0xFFFFFFFF:
  - Register 2 becomes 0xFF22FF44.
  - bvalid appears the cycle after the AW handshake.
- Write to 0x00 (RO): SLVERR, register 0 unchanged, no pulse.
- Write to 0x40: DECERR. Read of 0x40: rdata 0 with DECERR.
- bready held low for 5 cycles:
  - bvalid and bresp stay stable and s_awready and s_wready stay low.
  - A concurrent read of 0x04 completes normally.
- Same-edge AR and write commit to 0x0C (old value 0xA, new value 0xB):
  - The read returns 0xA.
  - A subsequent read returns 0xB.
- rst asserted while bvalid is pending:
  - bvalid drops and all registers return to 0.
  - After rst deasserts, a fresh write completes with OKAY.
